// File: rtl/chess_pkg.sv
// Piece codes, piece-kind decoding and the signed step type shared by the move generator.
// Pure declarations: no latency, no backpressure.
// Codes outside 1..12 decode to K_NONE so callers can reject them.
package chess_pkg;

    typedef enum logic [3:0] {
        EMPTY    = 4'd0,
        W_PAWN   = 4'd1,
        W_BISHOP = 4'd2,
        W_KNIGHT = 4'd3,
        W_ROOK   = 4'd4,
        W_QUEEN  = 4'd5,
        W_KING   = 4'd6,
        B_PAWN   = 4'd7,
        B_BISHOP = 4'd8,
        B_KNIGHT = 4'd9,
        B_ROOK   = 4'd10,
        B_QUEEN  = 4'd11,
        B_KING   = 4'd12
    } piece_t;

    typedef enum logic [2:0] {
        K_PAWN, K_BISHOP, K_KNIGHT, K_ROOK, K_QUEEN, K_KING, K_NONE
    } kind_t;

    typedef struct packed {
        logic signed [2:0] dr;
        logic signed [2:0] dc;
    } dir_t;

    function automatic logic is_white(input logic [7:0] c);
        return (c >= 8'(W_PAWN)) && (c <= 8'(W_KING));
    endfunction

    function automatic logic is_black(input logic [7:0] c);
        return (c >= 8'(B_PAWN)) && (c <= 8'(B_KING));
    endfunction

    function automatic logic is_empty(input logic [7:0] c);
        return c == 8'(EMPTY);
    endfunction

    function automatic kind_t piece_kind(input logic [7:0] c);
        if (is_white(c)) return kind_t'(3'(c - 8'd1));
        if (is_black(c)) return kind_t'(3'(c - 8'd7));
        return K_NONE;
    endfunction

    function automatic dir_t mk_dir(input int dr, input int dc);
        dir_t d;
        d.dr = 3'(dr);
        d.dc = 3'(dc);
        return d;
    endfunction

endpackage

// File: rtl/figure_dir_rom.sv
// Direction table: (piece kind, colour, direction index) -> step offset, slide flag, last-direction flag.
// Latency: combinational.
// Backpressure: none, pure lookup.
module figure_dir_rom
    import chess_pkg::*;
(
    input  kind_t      kind,
    input  logic       white,
    input  logic [2:0] idx,
    output dir_t       dir,
    output logic       slides,
    output logic       last_dir
);

    function automatic dir_t ortho(input logic [1:0] i);
        case (i)
            2'd0:    return mk_dir(1, 0);
            2'd1:    return mk_dir(-1, 0);
            2'd2:    return mk_dir(0, 1);
            default: return mk_dir(0, -1);
        endcase
    endfunction

    function automatic dir_t diag(input logic [1:0] i);
        case (i)
            2'd0:    return mk_dir(1, 1);
            2'd1:    return mk_dir(1, -1);
            2'd2:    return mk_dir(-1, 1);
            default: return mk_dir(-1, -1);
        endcase
    endfunction

    function automatic dir_t leap(input logic [2:0] i);
        case (i)
            3'd0:    return mk_dir(1, 2);
            3'd1:    return mk_dir(2, 1);
            3'd2:    return mk_dir(2, -1);
            3'd3:    return mk_dir(1, -2);
            3'd4:    return mk_dir(-1, -2);
            3'd5:    return mk_dir(-2, -1);
            3'd6:    return mk_dir(-2, 1);
            default: return mk_dir(-1, 2);
        endcase
    endfunction

    always_comb begin
        dir      = '0;
        slides   = 1'b0;
        last_dir = 1'b1;
        case (kind)
            K_PAWN: begin
                // index 0 is the push, 1 and 2 are the capture diagonals
                dir      = mk_dir(white ? 1 : -1, (idx == 3'd1) ? -1 : ((idx == 3'd2) ? 1 : 0));
                last_dir = idx >= 3'd2;
            end
            K_ROOK: begin
                dir      = ortho(idx[1:0]);
                slides   = 1'b1;
                last_dir = idx >= 3'd3;
            end
            K_BISHOP: begin
                dir      = diag(idx[1:0]);
                slides   = 1'b1;
                last_dir = idx >= 3'd3;
            end
            K_QUEEN, K_KING: begin
                dir      = idx[2] ? diag(idx[1:0]) : ortho(idx[1:0]);
                slides   = kind == K_QUEEN;
                last_dir = idx == 3'd7;
            end
            K_KNIGHT: begin
                dir      = leap(idx);
                last_dir = idx == 3'd7;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/figure_move_gen_seq.sv
// Sequential pseudo-legal move-mask generator, probing the board RAM one square at a time.
// Latency: 2 cycles per probed square, 1 per direction change, plus INIT and FINISH; done is registered.
// Backpressure: start is ignored while busy; board RAM must return data the cycle after board_rd.
module figure_move_gen_seq
    import chess_pkg::*;
#(
    parameter int N      = 8,
    parameter int CODE_W = 4,
    parameter int POS_W  = 2 * $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CODE_W-1:0] figure,
    input  logic [POS_W-1:0]  position,
    output logic              board_rd,
    output logic [POS_W-1:0]  board_addr,
    input  logic [CODE_W-1:0] board_data,
    output logic              busy,
    output logic              done,
    output logic [N*N-1:0]    possible_moves
);

    localparam int H  = POS_W / 2;
    localparam int SW = H + 2;
    localparam int BW = $clog2(N * N);
    localparam logic signed [SW-1:0] NS = SW'(N);

    typedef enum logic [2:0] {IDLE, INIT, STEP, CHECK, NEXT_DIR, FINISH} state_t;

    state_t            state, state_nx;
    logic [CODE_W-1:0] fig_q;
    logic [H-1:0]      org_r, org_c, cur_r, cur_c, tgt_r, tgt_c;
    logic [2:0]        dir_idx;
    logic              first_q;
    logic [N*N-1:0]    mask_q;
    logic              busy_q, done_q;

    logic              white;
    kind_t             kind;
    dir_t              rom_dir;
    logic              rom_slides, rom_last;
    logic signed [2:0] ddr, ddc;
    logic signed [SW-1:0] tr, tc;
    logic              on_board;
    logic [BW-1:0]     bit_idx;
    logic [7:0]        bd;
    logic              pawn_fwd, set_bit, cont;
    logic [H-1:0]      start_row;

    assign white = is_white(8'(fig_q));
    assign kind  = piece_kind(8'(fig_q));

    figure_dir_rom u_rom (
        .kind     (kind),
        .white    (white),
        .idx      (dir_idx),
        .dir      (rom_dir),
        .slides   (rom_slides),
        .last_dir (rom_last)
    );

    // one guard bit plus sign bit so a knight leap past either edge never wraps
    assign ddr      = rom_dir.dr;
    assign ddc      = rom_dir.dc;
    assign tr       = signed'({2'b00, cur_r}) + SW'(ddr);
    assign tc       = signed'({2'b00, cur_c}) + SW'(ddc);
    assign on_board = (tr >= 0) && (tr < NS) && (tc >= 0) && (tc < NS);

    assign board_rd   = (state == STEP) && on_board;
    assign board_addr = board_rd ? {tr[H-1:0], tc[H-1:0]} : '0;

    assign bit_idx   = BW'(int'(tgt_r) * N + int'(tgt_c));
    assign bd        = 8'(board_data);
    assign pawn_fwd  = (kind == K_PAWN) && (dir_idx == 3'd0);
    assign start_row = white ? H'(1) : H'(N - 2);

    always_comb begin
        set_bit = 1'b0;
        cont    = 1'b0;
        if (is_empty(bd)) begin
            // pawn diagonals only ever capture; pushes may double from the start row
            set_bit = (kind != K_PAWN) || pawn_fwd;
            cont    = rom_slides || (pawn_fwd && first_q && (org_r == start_row));
        end else if (white ? is_black(bd) : is_white(bd)) begin
            set_bit = !pawn_fwd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = INIT;
            INIT:     state_nx = (kind == K_NONE) ? FINISH : STEP;
            STEP:     state_nx = on_board ? CHECK : NEXT_DIR;
            CHECK:    state_nx = cont ? STEP : NEXT_DIR;
            NEXT_DIR: state_nx = rom_last ? FINISH : STEP;
            FINISH:   state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fig_q   <= '0;
            org_r   <= '0;
            org_c   <= '0;
            cur_r   <= '0;
            cur_c   <= '0;
            tgt_r   <= '0;
            tgt_c   <= '0;
            dir_idx <= '0;
            first_q <= 1'b0;
            mask_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= state == FINISH;
            case (state)
                IDLE: if (start) begin
                    fig_q  <= figure;
                    org_r  <= position[POS_W-1:H];
                    org_c  <= position[H-1:0];
                    mask_q <= '0;
                    busy_q <= 1'b1;
                end
                INIT: begin
                    cur_r   <= org_r;
                    cur_c   <= org_c;
                    dir_idx <= '0;
                    first_q <= 1'b1;
                end
                STEP: begin
                    tgt_r <= tr[H-1:0];
                    tgt_c <= tc[H-1:0];
                end
                CHECK: begin
                    if (set_bit) mask_q[bit_idx] <= 1'b1;
                    if (cont) begin
                        cur_r   <= tgt_r;
                        cur_c   <= tgt_c;
                        first_q <= 1'b0;
                    end
                end
                NEXT_DIR: begin
                    dir_idx <= dir_idx + 3'd1;
                    cur_r   <= org_r;
                    cur_c   <= org_c;
                    first_q <= 1'b1;
                end
                FINISH: busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign possible_moves = mask_q;

endmodule

// File: tb/tb_figure_move_gen_seq.sv
// Scoreboard bench for figure_move_gen_seq: expected masks queued at issue, compared on done.
module tb_figure_move_gen_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  figure = '0;
    logic [5:0]  position = '0;
    logic        board_rd;
    logic [5:0]  board_addr;
    logic [3:0]  board_data = '0;
    logic        busy, done;
    logic [63:0] possible_moves;

    logic [3:0]  board [64];
    logic [63:0] sb [$];
    logic [63:0] mon_exp;
    int          total = 0;
    int          bad = 0;

    figure_move_gen_seq #(.N(8), .CODE_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .figure         (figure),
        .position       (position),
        .board_rd       (board_rd),
        .board_addr     (board_addr),
        .board_data     (board_data),
        .busy           (busy),
        .done           (done),
        .possible_moves (possible_moves)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (board_rd) board_data <= board[board_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending request");
            end else begin
                mon_exp = sb.pop_front();
                check("mask", possible_moves, mon_exp);
                check("busy_at_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    function automatic bit on(input int r, input int c);
        return r >= 0 && r < 8 && c >= 0 && c < 8;
    endfunction

    function automatic bit enemy(input int code, input bit white);
        return code != 0 && ((code <= 6) != white);
    endfunction

    // chess rules written out directly from the piece descriptions
    function automatic logic [63:0] ref_moves(input int fig, input int pos);
        logic [63:0] m;
        int dr8[8], dc8[8], kr[8], kc[8];
        bit white, slide, knight;
        int kind, r, c, f, lo, hi, rr, cc, dr, dc, code;
        m = '0;
        dr8 = '{1, -1, 0, 0, 1, 1, -1, -1};
        dc8 = '{0, 0, 1, -1, 1, -1, 1, -1};
        kr  = '{1, 2, 2, 1, -1, -2, -2, -1};
        kc  = '{2, 1, -1, -2, -2, -1, 1, 2};
        if (fig < 1 || fig > 12) return m;
        white = fig <= 6;
        kind  = white ? fig : fig - 6;
        r = pos / 8;
        c = pos % 8;
        if (kind == 1) begin
            f = white ? 1 : -1;
            if (on(r + f, c) && board[(r + f) * 8 + c] == 0) begin
                m[(r + f) * 8 + c] = 1'b1;
                if (r == (white ? 1 : 6) && on(r + 2 * f, c) && board[(r + 2 * f) * 8 + c] == 0)
                    m[(r + 2 * f) * 8 + c] = 1'b1;
            end
            for (int s = -1; s <= 1; s += 2)
                if (on(r + f, c + s) && enemy(int'(board[(r + f) * 8 + c + s]), white))
                    m[(r + f) * 8 + c + s] = 1'b1;
            return m;
        end
        knight = kind == 3;
        slide  = kind == 2 || kind == 4 || kind == 5;
        lo = (kind == 2) ? 4 : 0;
        hi = (kind == 4) ? 3 : 7;
        for (int d = lo; d <= hi; d++) begin
            dr = knight ? kr[d] : dr8[d];
            dc = knight ? kc[d] : dc8[d];
            rr = r + dr;
            cc = c + dc;
            while (on(rr, cc)) begin
                code = int'(board[rr * 8 + cc]);
                if (code != 0) begin
                    if (enemy(code, white)) m[rr * 8 + cc] = 1'b1;
                    break;
                end
                m[rr * 8 + cc] = 1'b1;
                if (!slide) break;
                rr += dr;
                cc += dc;
            end
        end
        return m;
    endfunction

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 4'd0;
    endtask

    task automatic wait_done(inout int lat);
        while (done !== 1'b1 && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL timeout: got no done after %0d cycles expected done", lat);
            sb.delete();
        end
    endtask

    task automatic run(input int fig, input int pos, input logic [63:0] exp, output int lat);
        sb.push_back(exp);
        @(negedge clk);
        figure   = 4'(fig);
        position = 6'(pos);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        wait_done(lat);
    endtask

    int lat;
    int fig, pos;

    initial begin
        clear_board();
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_board_rd", {63'd0, board_rd}, 64'd0);
        check("rst_board_addr", {58'd0, board_addr}, 64'd0);
        check("rst_moves", possible_moves, 64'd0);
        rst = 1'b0;

        // rook in the corner, single done pulse
        board[0] = 4'd4;
        run(4, 0, 64'h01010101010101FE, lat);
        @(negedge clk);
        check("rook_done_single", {63'd0, done}, 64'd0);
        check("rook_busy_after", {63'd0, busy}, 64'd0);

        // knight, then with own piece on 10
        clear_board();
        board[0] = 4'd3;
        run(3, 0, 64'h0000000000020400, lat);
        board[10] = 4'd1;
        run(3, 0, 64'h0000000000020000, lat);

        // pawn push, capture, block
        clear_board();
        board[12] = 4'd1;
        run(1, 12, 64'h0000000010100000, lat);
        board[19] = 4'd7;
        run(1, 12, 64'h0000000010180000, lat);
        board[20] = 4'd9;
        run(1, 12, 64'h0000000000080000, lat);

        // queen with own blocker and enemy capture
        clear_board();
        board[0] = 4'd5;
        board[9] = 4'd7;
        board[1] = 4'd1;
        run(5, 0, 64'h0101010101010300, lat);

        // reset in the middle of a queen scan
        clear_board();
        board[27] = 4'd5;
        @(negedge clk);
        figure = 4'd5; position = 6'd27; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_moves", possible_moves, 64'd0);
        run(5, 27, ref_moves(5, 27), lat);

        // second start while busy must be ignored
        clear_board();
        board[0] = 4'd4;
        sb.push_back(64'h01010101010101FE);
        @(negedge clk);
        figure = 4'd4; position = 6'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        figure = 4'd3; position = 6'd30; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        wait_done(lat);

        // invalid codes: empty mask, done three cycles after accept
        run(0, 9, 64'd0, lat);
        check("invalid0_latency", 64'(lat), 64'd3);
        board[20] = 4'd4;
        run(13, 20, 64'd0, lat);
        check("invalid13_latency", 64'(lat), 64'd3);

        // random boards against the reference model
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 64; i++)
                board[i] = ($urandom_range(0, 9) < 6) ? 4'd0 : 4'($urandom_range(1, 12));
            fig = int'($urandom_range(1, 12));
            pos = int'($urandom_range(0, 63));
            board[pos] = 4'(fig);
            run(fig, pos, ref_moves(fig, pos), lat);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
